// File: rtl/prog_loader.sv
// Program loader: receives a header byte N, then N 16-bit words (high byte first),
// writes them to a 256x16 program memory and holds the CPU in reset meanwhile.
// Define LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module prog_loader #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wr,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] LO    = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM  = 3'd5;
`endif
  localparam logic [2:0] FIN   = 3'd6;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

  logic [2:0]  state;
  logic [7:0]  hdr_n;
  logic [15:0] idle_cnt;
  logic [8:0]  target;
  logic        accept;
  logic        timeout_hit;
  logic        last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum;
  logic [7:0]  csum_total;
  assign byte_ready = (state == HDR) || (state == HI) || (state == LO) || (state == CSUM);
  assign csum_total = sum + byte_in;
`else
  assign byte_ready = (state == HDR) || (state == HI) || (state == LO);
`endif

  assign accept      = byte_valid && byte_ready;
  assign mem_wr      = (state == WRITE);
  // A header of zero encodes a full 256-word image.
  assign target      = (hdr_n == 8'd0) ? 9'd256 : {1'b0, hdr_n};
  assign last_word   = ((word_cnt + 9'd1) == target);
  assign timeout_hit = byte_ready && !accept && (({1'b0, idle_cnt} + 17'd1) == TIMEOUT_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hdr_n    <= 8'd0;
      idle_cnt <= 16'd0;
      mem_addr <= 8'd0;
      mem_data <= 16'd0;
      word_cnt <= 9'd0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state    <= HDR;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= 9'd0;
            mem_addr <= 8'd0;
            idle_cnt <= 16'd0;
            cpu_hold <= 1'b1;
          end
        end
        HDR: if (accept) begin
          hdr_n <= byte_in;
          state <= HI;
        end
        HI: if (accept) begin
          mem_data[15:8] <= byte_in;
          state          <= LO;
        end
        LO: if (accept) begin
          mem_data[7:0] <= byte_in;
          state         <= WRITE;
        end
        WRITE: begin
          mem_addr <= mem_addr + 8'd1;
          word_cnt <= word_cnt + 9'd1;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CSUM;
`else
            state    <= FIN;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state <= HI;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (accept) begin
          state    <= FIN;
          cpu_hold <= 1'b0;
          if (csum_total == 8'd0) done <= 1'b1;
          else                    err  <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase

      // Inter-byte watchdog; overrides the state step above when it fires.
      if (byte_ready) begin
        if (accept) begin
          idle_cnt <= 16'd0;
        end else if (timeout_hit) begin
          idle_cnt <= 16'd0;
          state    <= FIN;
          err      <= 1'b1;
          done     <= 1'b0;
          cpu_hold <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 16'd1;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= 8'd0;
    end else if (((state == IDLE) || (state == FIN)) && start) begin
      sum <= 8'd0;
    end else if (accept && (state != CSUM)) begin
      sum <= csum_total;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (TIMEOUT=8); checksum scenarios build only when
// LOADER_CHECKSUM_EN is defined, and streams then carry a trailing checksum byte.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_wr;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [8:0]  word_cnt;

  int tests = 0;
  int fails = 0;
  int nwr = 0;
  logic [7:0]  wa [0:511];
  logic [15:0] wd [0:511];
  logic [7:0]  sum_tb = 8'd0;

  prog_loader #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_wr(mem_wr), .cpu_hold(cpu_hold), .done(done),
    .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr) begin
      if (nwr < 512) begin
        wa[nwr] = mem_addr;
        wd[nwr] = mem_data;
      end
      nwr = nwr + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(negedge clk);
    start  = 1'b1;
    sum_tb = 8'd0;
    nwr    = 0;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit st);
    bit got;
    got = 0;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    start      = st;
    for (int i = 0; i < 50 && !got; i++) begin
      if (byte_ready) begin
        @(posedge clk);
        got = 1;
      end else begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    sum_tb = sum_tb + b;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_byte: byte %h not accepted, got ready=%b required 1", b, byte_ready);
    end
  endtask

  task automatic send_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = 8'(8'd0 - sum_tb);
    send_byte(c, 0);
`endif
  endtask

  task automatic idle_bus();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wait_end(input int maxc, input string name);
    int k;
    k = 0;
    while (!(done || err) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!(done || err)) begin
      fails++;
      $display("FAIL %s_end: done=%b err=%b after %0d cycles, required completion", name, done, err, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({byte_ready, mem_wr, cpu_hold, done, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 00000", {byte_ready, mem_wr, cpu_hold, done, err});
    end
    tests++;
    if (mem_addr !== 8'd0 || mem_data !== 16'd0 || word_cnt !== 9'd0) begin
      fails++;
      $display("FAIL reset_data: addr=%h data=%h cnt=%0d required 0/0/0", mem_addr, mem_data, word_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_start();
    tests++;
    if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_hold: cpu_hold=%b ready=%b required 1/1", cpu_hold, byte_ready);
    end
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hAB, 0); send_byte(8'hCD, 0);
    send_csum();
    idle_bus();
    wait_end(20, "basic");
    tests++;
    if (nwr !== 2 || wa[0] !== 8'd0 || wd[0] !== 16'h1234 || wa[1] !== 8'd1 || wd[1] !== 16'hABCD) begin
      fails++;
      $display("FAIL basic_writes: n=%0d %h:%h %h:%h required 2 00:1234 01:abcd", nwr, wa[0], wd[0], wa[1], wd[1]);
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 9'd2 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL basic_status: done=%b err=%b cnt=%0d hold=%b required 1/0/2/0", done, err, word_cnt, cpu_hold);
    end
  endtask

  task automatic test_wrap();
    int bad;
    do_start();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'(i) ^ 8'hA5, 0);
    end
    send_csum();
    idle_bus();
    wait_end(20, "wrap");
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (wa[i] !== 8'(i) || wd[i] !== {8'(i), 8'(i) ^ 8'hA5}) bad++;
    tests++;
    if (nwr !== 256 || bad !== 0) begin
      fails++;
      $display("FAIL wrap_writes: n=%0d bad=%0d required 256/0", nwr, bad);
    end
    tests++;
    if (mem_addr !== 8'd0 || word_cnt !== 9'd256 || done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL wrap_status: addr=%h cnt=%0d done=%b err=%b required 00/256/1/0", mem_addr, word_cnt, done, err);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    do_start();
    send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    cycles = 0;
    for (int i = 0; i < 30 && !err; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      cycles++;
    end
    tests++;
    if (cycles !== 10) begin
      fails++;
      $display("FAIL timeout_latency: err after %0d cycles required 10", cycles);
    end
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || nwr !== 1 || word_cnt !== 9'd1) begin
      fails++;
      $display("FAIL timeout_status: err=%b done=%b hold=%b writes=%0d cnt=%0d required 1/0/0/1/1",
               err, done, cpu_hold, nwr, word_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hAB, 0);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({byte_ready, mem_wr, cpu_hold, done, err} !== 5'b0 || mem_addr !== 8'd0 ||
        mem_data !== 16'd0 || word_cnt !== 9'd0) begin
      fails++;
      $display("FAIL midreset_outputs: flags=%b addr=%h data=%h cnt=%0d required all 0",
               {byte_ready, mem_wr, cpu_hold, done, err}, mem_addr, mem_data, word_cnt);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (nwr !== 1) begin
      fails++;
      $display("FAIL midreset_nowrite: writes=%0d required 1", nwr);
    end
    do_start();
    send_byte(8'h01, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    send_csum();
    idle_bus();
    wait_end(20, "reload");
    tests++;
    if (nwr !== 1 || wa[0] !== 8'd0 || wd[0] !== 16'h5566 || done !== 1'b1 || word_cnt !== 9'd1) begin
      fails++;
      $display("FAIL reload: n=%0d %h:%h done=%b cnt=%0d required 1 00:5566 1 1", nwr, wa[0], wd[0], done, word_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_start();
    send_byte(8'h03, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'h03, 1); send_byte(8'h04, 0); send_byte(8'h05, 1); send_byte(8'h06, 0);
    send_csum();
    idle_bus();
    wait_end(20, "b2b");
    tests++;
    if (nwr !== 3 || wd[0] !== 16'h0102 || wd[1] !== 16'h0304 || wd[2] !== 16'h0506 || wa[2] !== 8'd2) begin
      fails++;
      $display("FAIL b2b_writes: n=%0d %h %h %h@%h required 3 0102 0304 0506@02", nwr, wd[0], wd[1], wd[2], wa[2]);
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || word_cnt !== 9'd3) begin
      fails++;
      $display("FAIL b2b_status: done=%b err=%b cnt=%0d required 1/0/3", done, err, word_cnt);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hFE, 0);
    idle_bus();
    wait_end(20, "csum_ok");
    tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL csum_match: done=%b err=%b required 1/0", done, err);
    end
    do_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hFF, 0);
    idle_bus();
    wait_end(20, "csum_bad");
    tests++;
    if (done !== 1'b0 || err !== 1'b1 || nwr !== 1) begin
      fails++;
      $display("FAIL csum_mismatch: done=%b err=%b writes=%0d required 0/1/1", done, err, nwr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
